// File: rtl/swap_pair_fifo_if.sv
// Handshake bundle between the swapper, the swap_pair_fifo and its consumer.
// SWAP_PAIR_FIFO_CHECK_EN adds the pre-swap operands and the sticky swap_err flag.
interface swap_pair_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [CW-1:0]    count;
   logic [CW-1:0]    hwm;
`ifdef SWAP_PAIR_FIFO_CHECK_EN
   logic [WIDTH-1:0] orig_a;
   logic [WIDTH-1:0] orig_b;
   logic             swap_err;
`endif

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
`ifdef SWAP_PAIR_FIFO_CHECK_EN
      input  orig_a, orig_b,
      output swap_err,
`endif
      output in_ready, out_valid, out_a, out_b, count, hwm
   );

   modport master (
      output in_valid, in_a, in_b, out_ready,
`ifdef SWAP_PAIR_FIFO_CHECK_EN
      output orig_a, orig_b,
      input  swap_err,
`endif
      input  in_ready, out_valid, out_a, out_b, count, hwm
   );
endinterface

// File: rtl/swap_pair_fifo.sv
// Circular FIFO of swapped operand pairs with occupancy and high-water mark.
// Optional swap checker enabled by SWAP_PAIR_FIFO_CHECK_EN.
module swap_pair_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             rst,
   swap_pair_fifo_if.slave bus
);
   localparam int            AW   = $clog2(DEPTH);
   localparam int            CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      hwm_q, hwm_d;
   logic               push_s, pop_s;
   logic               not_full_s, not_empty_s;
   logic [2*WIDTH-1:0] head_s;

   assign not_full_s  = (count_q != FULL);
   assign not_empty_s = (count_q != {CW{1'b0}});
   assign head_s      = mem_q[rd_ptr_q];

   assign bus.in_ready  = not_full_s;
   assign bus.out_valid = not_empty_s;
   assign bus.out_a     = not_empty_s ? head_s[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}};
   assign bus.out_b     = not_empty_s ? head_s[WIDTH-1:0]       : {WIDTH{1'b0}};
   assign bus.count     = count_q;
   assign bus.hwm       = hwm_q;

   // Next-state for pointers, occupancy and high-water mark.
   always_comb begin
      push_s   = bus.in_valid & not_full_s;
      pop_s    = bus.out_ready & not_empty_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (count_d > hwm_q) begin
         hwm_d = count_d;
      end else begin
         hwm_d = hwm_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         hwm_q    <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hwm_q    <= hwm_d;
      end
   end

   // Pair storage; never reset, stale slots are masked by count.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
      end
   end

`ifdef SWAP_PAIR_FIFO_CHECK_EN
   logic [2*WIDTH-1:0] orig_mem_q [DEPTH];
   logic [2*WIDTH-1:0] orig_head_s;
   logic               swap_err_q, swap_err_d;

   assign orig_head_s  = orig_mem_q[rd_ptr_q];
   assign bus.swap_err = swap_err_q;

   // A correct swap has out_a == orig_b and out_b == orig_a.
   always_comb begin
      swap_err_d = swap_err_q;
      if (pop_s && ((bus.out_a != orig_head_s[WIDTH-1:0]) ||
                    (bus.out_b != orig_head_s[2*WIDTH-1:WIDTH]))) begin
         swap_err_d = 1'b1;
      end else begin
         swap_err_d = swap_err_q;
      end
   end

   // Sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         swap_err_q <= 1'b0;
      end else begin
         swap_err_q <= swap_err_d;
      end
   end

   // Pre-swap operands stored alongside each pair.
   always_ff @(posedge clk) begin
      if (push_s) begin
         orig_mem_q[wr_ptr_q] <= {bus.orig_a, bus.orig_b};
      end
   end
`endif

endmodule
